dm_arbiter: RTL and testbench

- Arbitrates one shared single-port data memory between NUM_CORES processor cores using round-robin.
- Each core issues one read or write at a time with a req/ack handshake.
- The arbiter sequences the memory port (enable, write-enable, address, write data) and returns read data with a one-cycle ack pulse.
- Sits between the cores' data-memory ports and the shared data RAM at the top level.

---
 rtl/dm_arbiter.sv | 142 ++++++++++++++
 tb/tb_dm_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one single-port data RAM among NUM_CORES cores.
// One access in flight at a time; each transaction spans MEM_LAT+3 cycles from grant back to IDLE.
module dm_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          wr,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          ack,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_wr_q, is_wr_d;
  logic [NUM_CORES-1:0]   gnt_q, gnt_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;

  // Search starts one past the previous winner so every requester is reached within NUM_CORES-1 grants.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_CORES);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    gnt_d       = gnt_q;
    ack_d       = ack_q;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          rr_ptr_d    = win_idx;
          gnt_d       = NUM_CORES'(1) << win_idx;
          is_wr_d     = wr[win_idx];
          mem_en_d    = 1'b1;
          mem_we_d    = wr[win_idx];
          mem_addr_d  = addr[win_idx*ADDR_W +: ADDR_W];
          mem_wdata_d = wdata[win_idx*DATA_W +: DATA_W];
          cnt_d       = CNT_W'(MEM_LAT);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // cnt reaches zero on the edge where RAM read data has been valid for one full cycle
        if (cnt_q == '0) begin
          ack_d   = gnt_q;
          state_d = DONE;
          if (!is_wr_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDX_W'(NUM_CORES - 1);
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with its own RAM model,
// checked every cycle against a transaction-timeline reference model plus literal expectations.
module tb_dm_arbiter;
  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            rst;
  logic [1:0][NC-1:0]    req, wr, gnt, ack;
  logic [1:0][NC*AW-1:0] addr;
  logic [1:0][NC*DW-1:0] wdata;
  logic [1:0][DW-1:0]    rdata, mem_wdata, mem_rdata;
  logic [1:0]            mem_en, mem_we;
  logic [1:0][AW-1:0]    mem_addr;

  dm_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .gnt(gnt[0]), .ack(ack[0]), .rdata(rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  dm_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .gnt(gnt[1]), .ack(ack[1]), .rdata(rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  function automatic int lat(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  // Unwritten locations read as a fixed function of the address (0x0010 -> 0x5A).
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h4A;
  endfunction

  // RAM models: data appears MEM_LAT-1 edges after the sampling edge, garbage otherwise.
  logic [DW-1:0] ram   [2][65536];
  bit            ram_w [2][65536];
  logic [DW-1:0] pipe  [2][3];
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (mem_en[l] && mem_we[l]) begin
        ram[l][mem_addr[l]]   <= mem_wdata[l];
        ram_w[l][mem_addr[l]] <= 1'b1;
      end
      pipe[l][0] <= (mem_en[l] && !mem_we[l]) ?
                    (ram_w[l][mem_addr[l]] ? ram[l][mem_addr[l]] : init_val(mem_addr[l])) :
                    DW'($urandom);
      pipe[l][1] <= pipe[l][0];
      pipe[l][2] <= pipe[l][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // Reference model state
  int            t [2];
  int            rrm [2];
  int            gm [2];
  bit            cwr [2];
  logic [NC-1:0] e_gnt [2];
  logic [NC-1:0] e_ack [2];
  logic [DW-1:0] e_rd [2];
  logic [DW-1:0] e_wd [2];
  logic          e_en [2];
  logic          e_we [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] emem   [2][65536];
  bit            emem_w [2][65536];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rnd = 1'b0;
  logic [1:0][NC-1:0] rereq;
  int ack_cnt [2][NC];
  int gq [$];
  int aq [$];

  function automatic logic [DW-1:0] emval(input int l, input logic [AW-1:0] a);
    return emem_w[l][a] ? emem[l][a] : init_val(a);
  endfunction

  function automatic int oh2i(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v == (NC'(1) << i)) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // One edge of the reference model: a transaction is a timeline t = 0 .. MEM_LAT+2 after grant.
  task automatic model_edge();
    for (int l = 0; l < 2; l++) begin
      if (rst[l]) begin
        t[l] = -1; rrm[l] = NC - 1; e_gnt[l] = '0; e_ack[l] = '0; e_rd[l] = '0;
        e_en[l] = 1'b0; e_we[l] = 1'b0; e_addr[l] = '0; e_wd[l] = '0;
      end else if (t[l] < 0) begin
        e_en[l] = 1'b0; e_we[l] = 1'b0;
        if (req[l] != '0) begin
          int w;
          w = -1;
          for (int k = 1; k <= NC; k++)
            if (w < 0 && req[l][(rrm[l] + k) % NC]) w = (rrm[l] + k) % NC;
          rrm[l] = w; gm[l] = w; t[l] = 0;
          e_gnt[l] = NC'(1) << w; e_en[l] = 1'b1;
          cwr[l] = wr[l][w]; e_we[l] = wr[l][w];
          e_addr[l] = addr[l][w*AW +: AW]; e_wd[l] = wdata[l][w*DW +: DW];
          if (cwr[l]) begin
            emem[l][e_addr[l]] = e_wd[l];
            emem_w[l][e_addr[l]] = 1'b1;
          end
        end
      end else begin
        t[l]++;
        e_en[l] = 1'b0; e_we[l] = 1'b0;
        if (t[l] == lat(l) + 1) begin
          e_ack[l] = NC'(1) << gm[l];
          if (!cwr[l]) e_rd[l] = emval(l, e_addr[l]);
        end else if (t[l] == lat(l) + 2) begin
          e_ack[l] = '0; e_gnt[l] = '0; t[l] = -1;
        end
      end
    end
  endtask

  task automatic new_req(input int l, input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[l][i] = 1'b1;
    wr[l][i] = w;
    addr[l][i*AW +: AW] = a;
    wdata[l][i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d gnt", l),       32'(gnt[l]),       32'(e_gnt[l]));
      chk($sformatf("L%0d ack", l),       32'(ack[l]),       32'(e_ack[l]));
      chk($sformatf("L%0d rdata", l),     32'(rdata[l]),     32'(e_rd[l]));
      chk($sformatf("L%0d mem_en", l),    32'(mem_en[l]),    32'(e_en[l]));
      chk($sformatf("L%0d mem_we", l),    32'(mem_we[l]),    32'(e_we[l]));
      chk($sformatf("L%0d mem_addr", l),  32'(mem_addr[l]),  32'(e_addr[l]));
      chk($sformatf("L%0d mem_wdata", l), 32'(mem_wdata[l]), 32'(e_wd[l]));
    end
    if (mem_en[0]) gq.push_back(oh2i(gnt[0]));
    if (ack[0] != '0) aq.push_back(cyc);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < NC; i++) begin
        if (ack[l][i]) begin
          ack_cnt[l][i]++;
          req[l][i] = 1'b0;
          if (rereq[l][i]) new_req(l, i, 1'b0, {12'h000, 4'($urandom)}, 8'h00);
        end
        if (rnd) begin
          if (!req[l][i] && $urandom_range(3) == 0)
            new_req(l, i, 1'($urandom), {12'h000, 4'($urandom)}, DW'($urandom));
          else if (req[l][i] && $urandom_range(63) == 0)
            addr[l][i*AW +: AW] = {12'h000, 4'($urandom)};
        end
      end
      if (rnd) rst[l] = ($urandom_range(199) == 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = '1; req = '0; wr = '0; addr = '0; wdata = '0; rereq = '0;
    repeat (3) step();
    chk("rst gnt",       32'(gnt[0]),       32'h0);
    chk("rst ack",       32'(ack[0]),       32'h0);
    chk("rst rdata",     32'(rdata[0]),     32'h0);
    chk("rst mem_en",    32'(mem_en[0]),    32'h0);
    chk("rst mem_addr",  32'(mem_addr[1]),  32'h0);
    rst = '0;

    // Single read by core 2, MEM_LAT=1
    new_req(0, 2, 1'b0, 16'h0010, 8'h00);
    step();
    chk("rd1 gnt c0",    32'(gnt[0]),      32'h4);
    chk("rd1 mem_en c0", 32'(mem_en[0]),   32'h1);
    chk("rd1 addr c0",   32'(mem_addr[0]), 32'h0010);
    step();
    chk("rd1 ack c1",    32'(ack[0]),      32'h0);
    step();
    chk("rd1 ack c2",    32'(ack[0]),      32'h4);
    chk("rd1 rdata c2",  32'(rdata[0]),    32'h5A);
    step();
    chk("rd1 gnt c3",    32'(gnt[0]),      32'h0);

    // Core 1 write then read back
    new_req(0, 1, 1'b1, 16'h00FF, 8'hC3);
    step();
    chk("wr mem_we c0",  32'(mem_we[0]),    32'h1);
    chk("wr addr c0",    32'(mem_addr[0]),  32'h00FF);
    chk("wr wdata c0",   32'(mem_wdata[0]), 32'hC3);
    step();
    chk("wr mem_we c1",  32'(mem_we[0]),    32'h0);
    chk("wr mem_en c1",  32'(mem_en[0]),    32'h0);
    step();
    chk("wr ack c2",     32'(ack[0]),       32'h2);
    chk("wr rdata held", 32'(rdata[0]),     32'h5A);
    new_req(0, 1, 1'b0, 16'h00FF, 8'h00);
    step();
    step();
    chk("rb gnt c0",     32'(gnt[0]),       32'h2);
    step();
    step();
    chk("rb ack c2",     32'(ack[0]),       32'h2);
    chk("rb rdata c2",   32'(rdata[0]),     32'hC3);
    step();

    // All four cores at once after a fresh reset
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    gq.delete(); aq.delete();
    for (int i = 0; i < NC; i++) ack_cnt[0][i] = 0;
    for (int i = 0; i < NC; i++) new_req(0, i, 1'b0, AW'(16'h0020 + i), 8'h00);
    for (int k = 0; k < 40 && req[0] != '0; k++) step();
    chk("all4 drained", 32'(req[0]), 32'h0);
    chk("all4 n grants", 32'(gq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("all4 grant#%0d", k), 32'((k < gq.size()) ? gq[k] : -1), 32'(k));
    for (int k = 0; k < 3; k++)
      chk($sformatf("all4 ack gap#%0d", k),
          32'((k + 1 < aq.size()) ? aq[k+1] - aq[k] : -1), 32'd4);
    for (int i = 0; i < NC; i++)
      chk($sformatf("all4 acks core%0d", i), 32'(ack_cnt[0][i]), 32'd1);

    // Fairness: cores 0 and 1 re-request on every ack
    gq.delete();
    rereq[0][0] = 1'b1; rereq[0][1] = 1'b1;
    new_req(0, 0, 1'b0, 16'h0001, 8'h00);
    new_req(0, 1, 1'b0, 16'h0002, 8'h00);
    for (int k = 0; k < 60 && gq.size() < 6; k++) step();
    rereq[0] = '0;
    chk("fair n grants", 32'(gq.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("fair grant#%0d", k), 32'((k < gq.size()) ? gq[k] : -1), 32'(k % 2));
    for (int k = 0; k < 40 && req[0] != '0; k++) step();
    chk("fair drained", 32'(req[0]), 32'h0);

    // MEM_LAT=3: reset mid-WAIT, then simultaneous request from cores 0 and 3
    new_req(1, 0, 1'b0, 16'h0030, 8'h00);
    step();
    chk("abort gnt c0", 32'(gnt[1]), 32'h1);
    step();
    rst[1] = 1'b1;
    step();
    chk("abort gnt",       32'(gnt[1]),       32'h0);
    chk("abort ack",       32'(ack[1]),       32'h0);
    chk("abort mem_en",    32'(mem_en[1]),    32'h0);
    chk("abort mem_we",    32'(mem_we[1]),    32'h0);
    chk("abort mem_addr",  32'(mem_addr[1]),  32'h0);
    chk("abort mem_wdata", 32'(mem_wdata[1]), 32'h0);
    chk("abort rdata",     32'(rdata[1]),     32'h0);
    step();
    chk("rst+req gnt",     32'(gnt[1]),       32'h0);
    rst[1] = 1'b0;
    req[1][0] = 1'b0;
    repeat (2) step();
    new_req(1, 3, 1'b0, 16'h0031, 8'h00);
    new_req(1, 0, 1'b0, 16'h0032, 8'h00);
    step();
    chk("post-rst gnt",    32'(gnt[1]),       32'h1);
    for (int k = 0; k < 40 && req[1] != '0; k++) step();
    chk("post-rst drained", 32'(req[1]), 32'h0);
    repeat (2) step();

    // MEM_LAT=3 read of preloaded location
    new_req(1, 2, 1'b0, 16'h0010, 8'h00);
    step();
    chk("lat3 mem_en c0", 32'(mem_en[1]), 32'h1);
    chk("lat3 gnt c0",    32'(gnt[1]),    32'h4);
    step();
    chk("lat3 mem_en c1", 32'(mem_en[1]), 32'h0);
    step();
    step();
    chk("lat3 ack c3",    32'(ack[1]),    32'h0);
    step();
    chk("lat3 ack c4",    32'(ack[1]),    32'h4);
    chk("lat3 rdata c4",  32'(rdata[1]),  32'h5A);
    step();
    chk("lat3 gnt c5",    32'(gnt[1]),    32'h0);

    // Randomized traffic on both instances
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    rst = '0;
    for (int k = 0; k < 200 && (req[0] != '0 || req[1] != '0); k++) step();
    chk("rand drained L0", 32'(req[0]), 32'h0);
    chk("rand drained L1", 32'(req[1]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
